sqm_pwm_multi: RTL



---
 rtl/sqm_pkg.sv | 18 +
 rtl/sqm_sd_mod.sv | 32 +++
 rtl/sqm_pwm_multi.sv | 108 ++++++++++
 3 files changed

// File: rtl/sqm_pkg.sv
// Shared constants and helpers for the multi-channel sigma-delta/PWM audio converter.
package sqm_pkg;

   localparam logic MODE_PWM = 1'b0;
   localparam logic MODE_SD  = 1'b1;

   localparam int unsigned DIN_W_DEFAULT = 4;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/sqm_sd_mod.sv
// First-order sigma-delta modulator: the carry out of a running sum is the output bit.
module sqm_sd_mod #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in,
   input  logic             clr,
   output logic             out
);

   logic [WIDTH:0] acc_q, acc_d;

   // The carry bit is dropped before the next add; it only feeds the output.
   always_comb begin
      acc_d = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, in};
      if (clr) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign out = acc_q[WIDTH];

endmodule

// File: rtl/sqm_pwm_multi.sv
// Multi-channel 1-bit audio converter: per-channel PWM or sigma-delta plus a mixed
// sigma-delta output of all unmuted channels, with double-buffered level loading.
module sqm_pwm_multi
   import sqm_pkg::*;
#(
   parameter int unsigned CHANNELS = 6,
   parameter int unsigned DIN_W    = DIN_W_DEFAULT
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS*DIN_W-1:0] din,
   input  logic                      load,
   input  logic                      mode,
   input  logic [CHANNELS-1:0]       mute,
   output logic [CHANNELS-1:0]       pwm,
   output logic                      mix_pwm,
   output logic                      period_start
);

   localparam int unsigned SUM_W = DIN_W + clog2(CHANNELS);
   // Period is 2^DIN_W - 1 cycles, so the last count is 2^DIN_W - 2.
   localparam logic [DIN_W-1:0] CNT_LAST = {{(DIN_W-1){1'b1}}, 1'b0};

   logic [DIN_W-1:0]          cnt_q, cnt_d;
   logic [CHANNELS*DIN_W-1:0] shadow_q, shadow_d;
   logic [CHANNELS*DIN_W-1:0] active_q, active_d;
   logic                      mode_q, mode_d;
   logic                      boundary;
   logic                      acc_clr;
   logic [CHANNELS-1:0]       sd_bit;
   logic [CHANNELS-1:0]       pwm_d;
   logic [SUM_W-1:0]          sum;
   logic                      mix_bit;

   assign boundary = (cnt_q == CNT_LAST);
   assign acc_clr  = boundary && (mode != mode_q);

   // A load on the boundary cycle goes straight through to active.
   always_comb begin
      cnt_d    = boundary ? '0 : cnt_q + DIN_W'(1);
      shadow_d = load ? din : shadow_q;
      active_d = boundary ? shadow_d : active_q;
      mode_d   = boundary ? mode : mode_q;
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!mute[i]) begin
            sum = sum + SUM_W'(active_q[i*DIN_W +: DIN_W]);
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      sqm_sd_mod #(
         .WIDTH (DIN_W)
      ) u_sd (
         .clk     (clk),
         .reset_n (reset_n),
         .in      (active_q[g*DIN_W +: DIN_W]),
         .clr     (acc_clr),
         .out     (sd_bit[g])
      );
   end

   sqm_sd_mod #(
      .WIDTH (SUM_W)
   ) u_mix (
      .clk     (clk),
      .reset_n (reset_n),
      .in      (sum),
      .clr     (1'b0),
      .out     (mix_bit)
   );

   always_comb begin
      pwm_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (mode_q == MODE_SD) begin
            pwm_d[i] = !mute[i] && sd_bit[i];
         end else begin
            pwm_d[i] = !mute[i] && (active_q[i*DIN_W +: DIN_W] > cnt_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q        <= '0;
         shadow_q     <= '0;
         active_q     <= '0;
         mode_q       <= MODE_PWM;
         pwm          <= '0;
         mix_pwm      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         mode_q       <= mode_d;
         pwm          <= pwm_d;
         mix_pwm      <= mix_bit;
         period_start <= (cnt_q == '0);
      end
   end

endmodule
